// File: rtl/mem_test_driver_if.sv
// Memory-side bus of the march-test initiator: control and write data out,
// registered read data back.
interface mem_test_driver_if #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 256
);
    logic             sel;
    logic             we;
    logic [SIZE-1:0]  adr;
    logic [WIDTH-1:0] dat_o;
    logic [WIDTH-1:0] dat_i;

    modport master (output sel, output we, output adr, output dat_o, input dat_i);
    modport slave  (input sel, input we, input adr, input dat_o, output dat_i);
endinterface

// File: rtl/mem_test_driver.sv
// Two-pass march BIST initiator: write P(a) then read/compare, then the same
// with ~P(a); reports pass, saturating error count and first failing address.
module mem_test_driver #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 256
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    mem_test_driver_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [SIZE:0]          err_cnt,
    output logic [SIZE-1:0]        err_adr
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    localparam logic [SIZE-1:0] ADR_MAX = {SIZE{1'b1}};
    localparam logic [SIZE-1:0] ADR_ONE = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE:0]   CNT_MAX = {(SIZE+1){1'b1}};
    localparam logic [SIZE:0]   CNT_ONE = {{SIZE{1'b0}}, 1'b1};

    state_t           state, state_n;
    logic             pass_sel, pass_sel_n;
    logic             sel_n, we_n, busy_n, done_n, pass_n;
    logic [SIZE-1:0]  adr_n, err_adr_n, cmp_adr, cmp_adr_n;
    logic [WIDTH-1:0] dat_n, cmp_exp, cmp_exp_n;
    logic [SIZE:0]    err_cnt_n;
    logic             err_seen, err_seen_n, cmp_vld, cmp_vld_n, mismatch;

    // Address replicated upward from bit 0, top copy truncated; inverted in pass 1.
    function automatic logic [WIDTH-1:0] pattern(input logic [SIZE-1:0] a, input logic inv);
        logic [WIDTH-1:0] p;
        for (int i = 0; i < WIDTH; i++) p[i] = a[i % SIZE];
        return inv ? ~p : p;
    endfunction

    always_comb begin
        // The compare stage runs independently of the sequencer below.
        mismatch   = cmp_vld && (bus.dat_i != cmp_exp);
        err_cnt_n  = err_cnt;
        err_adr_n  = err_adr;
        err_seen_n = err_seen;
        if (mismatch) begin
            if (err_cnt != CNT_MAX) err_cnt_n = err_cnt + CNT_ONE;
            if (!err_seen) begin
                err_seen_n = 1'b1;
                err_adr_n  = cmp_adr;
            end
        end

        state_n    = state;
        pass_sel_n = pass_sel;
        sel_n      = bus.sel;
        we_n       = bus.we;
        adr_n      = bus.adr;
        dat_n      = bus.dat_o;
        busy_n     = busy;
        done_n     = done;
        pass_n     = pass;
        cmp_vld_n  = 1'b0;
        cmp_exp_n  = cmp_exp;
        cmp_adr_n  = cmp_adr;

        case (state)
            IDLE, FINISH: begin
                if (start) begin
                    state_n    = WRITE;
                    pass_sel_n = 1'b0;
                    sel_n      = 1'b1;
                    we_n       = 1'b1;
                    adr_n      = '0;
                    dat_n      = pattern('0, 1'b0);
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                    err_cnt_n  = '0;
                    err_adr_n  = '0;
                    err_seen_n = 1'b0;
                end
            end
            WRITE: begin
                if (bus.adr == ADR_MAX) begin
                    state_n = READ;
                    we_n    = 1'b0;
                    adr_n   = '0;
                end else begin
                    adr_n = bus.adr + ADR_ONE;
                    dat_n = pattern(bus.adr + ADR_ONE, pass_sel);
                end
            end
            READ: begin
                cmp_vld_n = 1'b1;
                cmp_exp_n = pattern(bus.adr, pass_sel);
                cmp_adr_n = bus.adr;
                if (bus.adr == ADR_MAX) begin
                    state_n = DRAIN;
                    sel_n   = 1'b0;
                    adr_n   = '0;
                end else begin
                    adr_n = bus.adr + ADR_ONE;
                end
            end
            DRAIN: begin
                if (!pass_sel) begin
                    state_n    = WRITE;
                    pass_sel_n = 1'b1;
                    sel_n      = 1'b1;
                    we_n       = 1'b1;
                    adr_n      = '0;
                    dat_n      = pattern('0, 1'b1);
                end else begin
                    // Final compare lands on this same edge, so judge on err_cnt_n.
                    state_n = FINISH;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                    pass_n  = (err_cnt_n == '0);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pass_sel  <= 1'b0;
            bus.sel   <= 1'b0;
            bus.we    <= 1'b0;
            bus.adr   <= '0;
            bus.dat_o <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_cnt   <= '0;
            err_adr   <= '0;
            err_seen  <= 1'b0;
            cmp_vld   <= 1'b0;
            cmp_exp   <= '0;
            cmp_adr   <= '0;
        end else begin
            state     <= state_n;
            pass_sel  <= pass_sel_n;
            bus.sel   <= sel_n;
            bus.we    <= we_n;
            bus.adr   <= adr_n;
            bus.dat_o <= dat_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_cnt   <= err_cnt_n;
            err_adr   <= err_adr_n;
            err_seen  <= err_seen_n;
            cmp_vld   <= cmp_vld_n;
            cmp_exp   <= cmp_exp_n;
            cmp_adr   <= cmp_adr_n;
        end
    end
endmodule

// File: tb/tb_mem_test_driver.sv
// Bench for mem_test_driver: behavioural 1-cycle memory with injectable read
// faults, bus-transaction and result scoreboards filled at start.
module tb_mem_test_driver;
    localparam int SIZE  = 4;
    localparam int WIDTH = 8;
    localparam int N     = 16;

    typedef struct {
        logic       we;
        logic [3:0] adr;
        logic [7:0] dat;
    } txn_t;

    typedef struct {
        logic [4:0] cnt;
        logic [3:0] eadr;
        logic       ok;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [4:0] err_cnt;
    logic [3:0] err_adr;

    int n_checks = 0;
    int n_fail   = 0;
    int fault_mode = 0;

    txn_t txq[$];
    res_t resq[$];

    logic [7:0] mem [N];
    logic [7:0] rd_word = '0;
    logic [3:0] rd_adr = '0;

    mem_test_driver_if #(.SIZE(SIZE), .WIDTH(WIDTH)) bus ();

    mem_test_driver #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .busy(busy), .done(done), .pass(pass),
        .err_cnt(err_cnt), .err_adr(err_adr)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] fault(input logic [7:0] w, input logic [3:0] a, input int mode);
        case (mode)
            1:       return (a == 4'd5) ? (w & 8'hFE) : w;
            2:       return 8'h00;
            3:       return ~w;
            default: return w;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (bus.sel) begin
            if (bus.we) mem[bus.adr] <= bus.dat_o;
            else begin
                rd_word <= mem[bus.adr];
                rd_adr  <= bus.adr;
            end
        end
    end

    always_comb bus.dat_i = fault(rd_word, rd_adr, fault_mode);

    task automatic fill_expected(input int mode);
        res_t r;
        logic [7:0] w;
        logic [7:0] got;
        logic seen;
        r.cnt = '0; r.eadr = '0; seen = 1'b0;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < N; a++) begin
                w = {a[3:0], a[3:0]};
                if (p == 1) w = ~w;
                txq.push_back('{1'b1, a[3:0], w});
            end
            for (int a = 0; a < N; a++) begin
                w = {a[3:0], a[3:0]};
                if (p == 1) w = ~w;
                txq.push_back('{1'b0, a[3:0], 8'h00});
                got = fault(w, a[3:0], mode);
                if (got != w) begin
                    if (r.cnt != 5'h1F) r.cnt = r.cnt + 5'd1;
                    if (!seen) begin seen = 1'b1; r.eadr = a[3:0]; end
                end
            end
        end
        r.ok = (r.cnt == 5'd0);
        resq.push_back(r);
    endtask

    // Start a run, scoreboard every bus cycle and the final result; done must
    // first be seen in cycle 4N+3 (edge 66 after the start edge).
    task automatic run_test(input int mode, input int restart_at, input string name);
        txn_t t;
        res_t r;
        bit   finished = 0;
        fault_mode = mode;
        fill_expected(mode);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 1; cyc <= 200 && !finished; cyc++) begin
            @(negedge clk);
            start = (cyc == restart_at);
            if (cyc == 1) begin
                n_checks++;
                if (busy !== 1'b1 || done !== 1'b0 || err_cnt !== 5'd0 || err_adr !== 4'd0) begin
                    n_fail++;
                    $display("FAIL %s start_clear: busy=%b done=%b err_cnt=%h err_adr=%h want 1 0 0 0",
                             name, busy, done, err_cnt, err_adr);
                end
            end
            if (bus.sel === 1'b1) begin
                n_checks++;
                if (txq.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s extra_access cycle %0d adr=%h we=%b", name, cyc, bus.adr, bus.we);
                end else begin
                    t = txq.pop_front();
                    if (bus.we !== t.we || bus.adr !== t.adr || (t.we && bus.dat_o !== t.dat)) begin
                        n_fail++;
                        $display("FAIL %s bus cycle %0d: we=%b adr=%h dat=%h want we=%b adr=%h dat=%h",
                                 name, cyc, bus.we, bus.adr, bus.dat_o, t.we, t.adr, t.dat);
                    end
                end
            end
            if (done === 1'b1) begin
                finished = 1;
                r = resq.pop_front();
                n_checks++;
                if (cyc != 4*N+3 || busy !== 1'b0 || bus.sel !== 1'b0 || txq.size() != 0) begin
                    n_fail++;
                    $display("FAIL %s done_timing: cycle=%0d busy=%b sel=%b left=%0d want cycle=%0d",
                             name, cyc, busy, bus.sel, txq.size(), 4*N+3);
                end
                n_checks++;
                if (err_cnt !== r.cnt || err_adr !== r.eadr || pass !== r.ok) begin
                    n_fail++;
                    $display("FAIL %s result: err_cnt=%h err_adr=%h pass=%b want %h %h %b",
                             name, err_cnt, err_adr, pass, r.cnt, r.eadr, r.ok);
                end
            end
        end
        start = 1'b0;
        if (!finished) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: done never rose", name);
            txq.delete();
            resq.delete();
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if (bus.sel !== 1'b0 || bus.we !== 1'b0 || bus.adr !== 4'd0 || bus.dat_o !== 8'd0 ||
            busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 5'd0 || err_adr !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: sel=%b we=%b adr=%h dat=%h busy=%b done=%b pass=%b cnt=%h eadr=%h want all 0",
                     bus.sel, bus.we, bus.adr, bus.dat_o, busy, done, pass, err_cnt, err_adr);
        end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_clean;       run_test(0, 0, "clean");     endtask
    task automatic test_bit_fault;   run_test(1, 0, "bit_fault"); endtask
    task automatic test_all_zero;    run_test(2, 0, "all_zero");  endtask
    task automatic test_saturate;    run_test(3, 0, "saturate");  endtask

    task automatic test_back_to_back;
        run_test(0, 10, "restart_ignored");
        run_test(0, 0, "rerun_after_done");
    endtask

    task automatic test_mid_reset;
        fault_mode = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (bus.sel !== 1'b1 || bus.we !== 1'b0 || bus.adr !== 4'd3) begin
            n_fail++;
            $display("FAIL mid_reset_pre: sel=%b we=%b adr=%h want 1 0 3", bus.sel, bus.we, bus.adr);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if (bus.sel !== 1'b0 || bus.we !== 1'b0 || bus.adr !== 4'd0 || bus.dat_o !== 8'd0 ||
            busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 || err_cnt !== 5'd0 || err_adr !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: sel=%b we=%b adr=%h busy=%b done=%b cnt=%h want all 0",
                     bus.sel, bus.we, bus.adr, busy, done, err_cnt);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.sel !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_reset_quiet cycle %0d: sel=%b busy=%b want 0 0", i, bus.sel, busy);
            end
        end
        run_test(0, 0, "after_reset");
    endtask

    initial begin
        test_reset();
        test_clean();
        test_bit_fault();
        test_all_zero();
        test_saturate();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
